mips_control_unit: RTL and testbench
====================================

// Module: mips_control_unit
// PURPOSE
//  Multicycle Moore FSM that drives every control input of the integer datapath
//  (S_Addr, T_Addr, D_Addr, D_En, FS, T_Sel, HILO_ld, Y_Sel) plus PC, IR and memory
//  strobes. Consumes the datapath status flags C/V/N/Z.
//  Sits beside the integer datapath in the CPU top level: instruction in, control word out.
// PARAMETERS
//  RESET_PC_SEL  2'b00  pc_sel value driven during RESET (PC load source)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset
//  IR         in   32  current instruction, held by top-level IR register
//  C,V,N,Z    in   1   datapath ALU status flags
//  pc_sel     out  2   PC source: 0=PC+4, 1=branch target, 2=jump target, 3=S register
//  pc_ld      out  1   load PC from pc_sel source
//  pc_inc     out  1   PC <= PC+4
//  im_cs      out  1   instruction memory chip select
//  im_rd      out  1   instruction memory read
//  ir_ld      out  1   IR <= instruction memory data
//  S_Addr     out  5   datapath S read address
//  T_Addr     out  5   datapath T read address
//  D_Addr     out  5   datapath write address
//  D_En       out  1   register file write enable
//  FS         out  5   ALU function select
//  T_Sel      out  1   1 = immediate (DT) into ALU T operand
//  ext_sel    out  1   DT extension: 0 = sign-extend, 1 = zero-extend IR[15:0]
//  HILO_ld    out  1   capture ALU Y_hi/Y_lo into HI/LO
//  Y_Sel      out  3   0=PC, 1=DY, 2=ALU lo, 3=LO, 4=HI
//  dm_cs      out  1   data memory chip select
//  dm_rd      out  1   data memory read
//  dm_wr      out  1   data memory write (data = datapath D_OUT)
//  halt       out  1   sticky; set on BREAK
//  illegal    out  1   sticky; set on an undecoded opcode/funct
// BEHAVIOUR
//  - Reset (reset==0, async): state=RESET, all outputs 0 except pc_sel=RESET_PC_SEL.
//  - Outputs are registered with the state (Moore); every strobe is high for exactly one cycle.
//  - RESET -> FETCH on the first clk after reset deasserts.
//  - FETCH: im_cs, im_rd, ir_ld, pc_inc -> DECODE.
//  - DECODE: S_Addr=IR[25:21], T_Addr=IR[20:16]; branch on op/funct.
//  - FS codes: PASS_S 00, PASS_T 01, ADD 02, ADDU 03, SUB 04, SUBU 05, SLT 06, SLTU 07,
//    AND 08, OR 09, XOR 0A, NOR 0B, SRL 0C, SRA 0D, SLL 0E, MUL 1E, DIV 1F.
//  - R-type ALU ops: RALU (FS per funct, Y_Sel=2, D_Addr=rd, D_En) -> FETCH.
//  - MULT/DIV: MD (FS=1E/1F, HILO_ld) -> FETCH.
//  - MFHI/MFLO: Y_Sel=4/3, D_Addr=rd, D_En -> FETCH.
//  - ADDI / ORI: IALU (T_Sel=1, ext_sel=0/1, FS=02/09, Y_Sel=2, D_Addr=rt, D_En) -> FETCH.
//  - LW: LW1 (FS=ADD, T_Sel=1; the top level registers the result as the address)
//    -> LW2 (dm_cs, dm_rd) -> LW3 (Y_Sel=1, D_Addr=rt, D_En) -> FETCH.
//  - SW: SW1 (FS=ADD, T_Sel=1) -> SW2 (dm_cs, dm_wr, T_Addr=rt, T_Sel=0) -> FETCH.
//  - BEQ/BNE: BR1 (FS=SUB, T_Sel=0). Z is sampled at the end of BR1.
//    Taken (BEQ&Z or BNE&!Z) -> BR2 (pc_sel=1, pc_ld) -> FETCH. Not taken -> FETCH.
//  - J: pc_sel=2, pc_ld -> FETCH.
//  - JAL: JAL1 (Y_Sel=0, D_Addr=31, D_En) -> JAL2 (pc_sel=2, pc_ld) -> FETCH.
//    Link value is the already-incremented PC.
//  - JR: pc_sel=3, pc_ld -> FETCH.
//  - BREAK: -> HALT. Unknown op/funct: illegal=1 -> HALT.
//    HALT is absorbing, with all strobes 0; only reset leaves it.
//  - D_En is never asserted with D_Addr=0, except R-type with rd=0 (the datapath ignores r0).
//  - V is ignored: no overflow trap.
//  - Reset mid-instruction aborts the sequence immediately; no partial memory write
//    completes after reset asserts.
// TESTING
//  1. Release reset -> FETCH next cycle with im_rd=ir_ld=pc_inc=1 for 1 cycle, then DECODE.
//  2. IR=0x014B4820 (add $9,$10,$11) -> RALU: FS=02, Y_Sel=2, D_Addr=9, D_En=1; FETCH after 3 cycles.
//  3. IR=0x8D280004 (lw $8,4($9)) -> LW1 FS=02 T_Sel=1; LW2 dm_rd=1; LW3 Y_Sel=1 D_Addr=8 D_En=1.
//  4. IR=0x11090003 (beq) with Z=1 -> BR2 pc_sel=1 pc_ld=1; with Z=0 -> FETCH, pc_ld never high.
//  5. IR=0x0109001A (div) -> FS=1F, HILO_ld=1 for 1 cycle; next IR=0x00005010 (mfhi $10) -> Y_Sel=4, D_Addr=10.
//  6. IR=0xFC000000 -> illegal=1, HALT held 100 cycles; reset pulse during LW2 -> dm_rd=0 at once, RESET.

Source files
------------

// File: rtl/mips_control_unit_if.sv
// Instruction/flag inputs and the full control word between the control unit and the datapath.
// Pure wiring, no latency.
// No flow control: every signal is a level, valid every cycle.
interface mips_control_unit_if;
  logic [31:0] IR;
  logic        C;
  logic        V;
  logic        N;
  logic        Z;
  logic [1:0]  pc_sel;
  logic        pc_ld;
  logic        pc_inc;
  logic        im_cs;
  logic        im_rd;
  logic        ir_ld;
  logic [4:0]  S_Addr;
  logic [4:0]  T_Addr;
  logic [4:0]  D_Addr;
  logic        D_En;
  logic [4:0]  FS;
  logic        T_Sel;
  logic        ext_sel;
  logic        HILO_ld;
  logic [2:0]  Y_Sel;
  logic        dm_cs;
  logic        dm_rd;
  logic        dm_wr;
  logic        halt;
  logic        illegal;

  // control unit side
  modport master (
    input  IR, C, V, N, Z,
    output pc_sel, pc_ld, pc_inc, im_cs, im_rd, ir_ld,
           S_Addr, T_Addr, D_Addr, D_En, FS, T_Sel, ext_sel, HILO_ld, Y_Sel,
           dm_cs, dm_rd, dm_wr, halt, illegal
  );

  // datapath / top-level side
  modport slave (
    output IR, C, V, N, Z,
    input  pc_sel, pc_ld, pc_inc, im_cs, im_rd, ir_ld,
           S_Addr, T_Addr, D_Addr, D_En, FS, T_Sel, ext_sel, HILO_ld, Y_Sel,
           dm_cs, dm_rd, dm_wr, halt, illegal
  );
endinterface

// File: rtl/mips_control_unit.sv
// Multicycle Moore FSM producing the integer datapath control word from IR and ALU flags.
// Control word is registered with the state: it changes on the edge that enters each state.
// No backpressure: one state per cycle, HALT absorbs until reset.
module mips_control_unit #(
  parameter logic [1:0] RESET_PC_SEL = 2'b00
) (
  input logic                 clk,
  input logic                 reset,
  mips_control_unit_if.master cu
);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_RALU, S_MD, S_MFX, S_IALU,
    S_LW1, S_LW2, S_LW3, S_SW1, S_SW2, S_BR1, S_BR2,
    S_JMP, S_JAL1, S_JAL2, S_JR, S_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       pc_ld;
    logic       pc_inc;
    logic       im_cs;
    logic       im_rd;
    logic       ir_ld;
    logic [4:0] s_addr;
    logic [4:0] t_addr;
    logic [4:0] d_addr;
    logic       d_en;
    logic [4:0] fs;
    logic       t_sel;
    logic       ext_sel;
    logic       hilo_ld;
    logic [2:0] y_sel;
    logic       dm_cs;
    logic       dm_rd;
    logic       dm_wr;
    logic       halt;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23,
                         OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_BREAK = 6'h0D, FN_MFHI = 6'h10, FN_MFLO = 6'h12,
                         FN_MULT = 6'h18, FN_DIV = 6'h1A;

  state_t     state, state_nxt;
  ctl_t       ctl_q, ctl_d;
  logic       set_halt, set_illegal;
  logic       is_ralu;
  logic [4:0] ralu_fs;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = cu.IR[31:26];
  assign rs    = cu.IR[25:21];
  assign rt    = cu.IR[20:16];
  assign rd    = cu.IR[15:11];
  assign funct = cu.IR[5:0];

  // Overflow is not trapped and C/N are not needed by any supported branch.
  logic unused_ok;
  assign unused_ok = ^{cu.C, cu.V, cu.N, cu.IR[10:6]};

  // R-type ALU funct to ALU function select
  always_comb begin
    is_ralu = 1'b1;
    ralu_fs = 5'h00;
    case (funct)
      6'h20:   ralu_fs = 5'h02;
      6'h21:   ralu_fs = 5'h03;
      6'h22:   ralu_fs = 5'h04;
      6'h23:   ralu_fs = 5'h05;
      6'h2A:   ralu_fs = 5'h06;
      6'h2B:   ralu_fs = 5'h07;
      6'h24:   ralu_fs = 5'h08;
      6'h25:   ralu_fs = 5'h09;
      6'h26:   ralu_fs = 5'h0A;
      6'h27:   ralu_fs = 5'h0B;
      6'h02:   ralu_fs = 5'h0C;
      6'h03:   ralu_fs = 5'h0D;
      6'h00:   ralu_fs = 5'h0E;
      default: is_ralu = 1'b0;
    endcase
  end

  // Next-state selection; decode happens only in DECODE while IR is stable
  always_comb begin
    state_nxt   = state;
    set_halt    = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE: begin
            if (is_ralu) state_nxt = S_RALU;
            else begin
              case (funct)
                FN_MULT, FN_DIV: state_nxt = S_MD;
                FN_MFHI, FN_MFLO: state_nxt = S_MFX;
                FN_JR:    state_nxt = S_JR;
                FN_BREAK: begin state_nxt = S_HALT; set_halt = 1'b1; end
                default:  begin state_nxt = S_HALT; set_illegal = 1'b1; end
              endcase
            end
          end
          OP_ADDI, OP_ORI: state_nxt = S_IALU;
          OP_LW:           state_nxt = S_LW1;
          OP_SW:           state_nxt = S_SW1;
          OP_BEQ, OP_BNE:  state_nxt = S_BR1;
          OP_J:            state_nxt = S_JMP;
          OP_JAL:          state_nxt = S_JAL1;
          default: begin state_nxt = S_HALT; set_illegal = 1'b1; end
        endcase
      end
      S_LW1:  state_nxt = S_LW2;
      S_LW2:  state_nxt = S_LW3;
      S_SW1:  state_nxt = S_SW2;
      S_BR1:  state_nxt = ((op == OP_BEQ && cu.Z) || (op == OP_BNE && !cu.Z)) ? S_BR2 : S_FETCH;
      S_JAL1: state_nxt = S_JAL2;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Control word for the state being entered; sticky flags accumulate
  always_comb begin
    ctl_d         = '0;
    ctl_d.halt    = ctl_q.halt | set_halt;
    ctl_d.illegal = ctl_q.illegal | set_illegal;
    case (state_nxt)
      S_FETCH: begin
        ctl_d.im_cs  = 1'b1;
        ctl_d.im_rd  = 1'b1;
        ctl_d.ir_ld  = 1'b1;
        ctl_d.pc_inc = 1'b1;
      end
      S_DECODE, S_RALU, S_MD, S_IALU, S_LW1, S_SW1, S_SW2, S_BR1, S_JR: begin
        ctl_d.s_addr = rs;
        ctl_d.t_addr = rt;
        case (state_nxt)
          S_RALU: begin
            ctl_d.fs     = ralu_fs;
            ctl_d.y_sel  = 3'd2;
            ctl_d.d_addr = rd;
            ctl_d.d_en   = 1'b1;
          end
          S_MD: begin
            ctl_d.fs      = (funct == FN_DIV) ? 5'h1F : 5'h1E;
            ctl_d.hilo_ld = 1'b1;
          end
          S_IALU: begin
            ctl_d.t_sel   = 1'b1;
            ctl_d.ext_sel = (op == OP_ORI);
            ctl_d.fs      = (op == OP_ORI) ? 5'h09 : 5'h02;
            ctl_d.y_sel   = 3'd2;
            ctl_d.d_addr  = rt;
            ctl_d.d_en    = (rt != 5'd0);
          end
          S_LW1, S_SW1: begin
            ctl_d.fs    = 5'h02;
            ctl_d.t_sel = 1'b1;
          end
          S_SW2: begin
            ctl_d.dm_cs = 1'b1;
            ctl_d.dm_wr = 1'b1;
          end
          S_BR1: ctl_d.fs = 5'h04;
          S_JR: begin
            ctl_d.pc_sel = 2'd3;
            ctl_d.pc_ld  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MFX: begin
        ctl_d.y_sel  = (funct == FN_MFHI) ? 3'd4 : 3'd3;
        ctl_d.d_addr = rd;
        ctl_d.d_en   = 1'b1;
      end
      S_LW2: begin
        ctl_d.dm_cs = 1'b1;
        ctl_d.dm_rd = 1'b1;
      end
      S_LW3: begin
        ctl_d.y_sel  = 3'd1;
        ctl_d.d_addr = rt;
        ctl_d.d_en   = (rt != 5'd0);
      end
      S_BR2: begin
        ctl_d.pc_sel = 2'd1;
        ctl_d.pc_ld  = 1'b1;
      end
      S_JMP, S_JAL2: begin
        ctl_d.pc_sel = 2'd2;
        ctl_d.pc_ld  = 1'b1;
      end
      S_JAL1: begin
        ctl_d.y_sel  = 3'd0;
        ctl_d.d_addr = 5'd31;
        ctl_d.d_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and control word registers; reset aborts any sequence immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RESET;
      ctl_q        <= '0;
      ctl_q.pc_sel <= RESET_PC_SEL;
    end else begin
      state <= state_nxt;
      ctl_q <= ctl_d;
    end
  end

  assign cu.pc_sel  = ctl_q.pc_sel;
  assign cu.pc_ld   = ctl_q.pc_ld;
  assign cu.pc_inc  = ctl_q.pc_inc;
  assign cu.im_cs   = ctl_q.im_cs;
  assign cu.im_rd   = ctl_q.im_rd;
  assign cu.ir_ld   = ctl_q.ir_ld;
  assign cu.S_Addr  = ctl_q.s_addr;
  assign cu.T_Addr  = ctl_q.t_addr;
  assign cu.D_Addr  = ctl_q.d_addr;
  assign cu.D_En    = ctl_q.d_en;
  assign cu.FS      = ctl_q.fs;
  assign cu.T_Sel   = ctl_q.t_sel;
  assign cu.ext_sel = ctl_q.ext_sel;
  assign cu.HILO_ld = ctl_q.hilo_ld;
  assign cu.Y_Sel   = ctl_q.y_sel;
  assign cu.dm_cs   = ctl_q.dm_cs;
  assign cu.dm_rd   = ctl_q.dm_rd;
  assign cu.dm_wr   = ctl_q.dm_wr;
  assign cu.halt    = ctl_q.halt;
  assign cu.illegal = ctl_q.illegal;

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed and random instruction streams against a per-instruction control-word model.
// Each instruction is checked cycle by cycle from FETCH to the next FETCH.
// No backpressure in the design; the bench advances one cycle per step.
module tb_mips_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_control_unit_if bus();

  mips_control_unit #(.RESET_PC_SEL(2'b11)) dut (
    .clk   (clk),
    .reset (reset),
    .cu    (bus)
  );

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       pc_ld, pc_inc, im_cs, im_rd, ir_ld;
    logic [4:0] s_addr, t_addr, d_addr;
    logic       d_en;
    logic [4:0] fs;
    logic       t_sel, ext_sel, hilo_ld;
    logic [2:0] y_sel;
    logic       dm_cs, dm_rd, dm_wr, halt, illegal;
  } cw_t;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  halted = 0;
  bit  ill = 0;
  cw_t exp_q[$];
  logic [4:0] fs_map [int];
  int  ralu_fn [0:12] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h02, 'h03};

  function automatic cw_t sample();
    cw_t w;
    w.pc_sel = bus.pc_sel;  w.pc_ld = bus.pc_ld;   w.pc_inc = bus.pc_inc;
    w.im_cs = bus.im_cs;    w.im_rd = bus.im_rd;   w.ir_ld = bus.ir_ld;
    w.s_addr = bus.S_Addr;  w.t_addr = bus.T_Addr; w.d_addr = bus.D_Addr;
    w.d_en = bus.D_En;      w.fs = bus.FS;         w.t_sel = bus.T_Sel;
    w.ext_sel = bus.ext_sel; w.hilo_ld = bus.HILO_ld; w.y_sel = bus.Y_Sel;
    w.dm_cs = bus.dm_cs;    w.dm_rd = bus.dm_rd;   w.dm_wr = bus.dm_wr;
    w.halt = bus.halt;      w.illegal = bus.illegal;
    return w;
  endfunction

  function automatic cw_t blank();
    cw_t w = '0;
    w.halt = halted;
    w.illegal = ill;
    return w;
  endfunction

  function automatic cw_t reset_word();
    cw_t w = '0;
    w.pc_sel = 2'b11;
    return w;
  endfunction

  function automatic cw_t fetch_word();
    cw_t w = blank();
    w.im_cs = 1'b1; w.im_rd = 1'b1; w.ir_ld = 1'b1; w.pc_inc = 1'b1;
    return w;
  endfunction

  task automatic check(input string tag, input cw_t exp);
    cw_t obs = sample();
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control words from DECODE up to (not including) the next FETCH.
  task automatic build_expect(input logic [31:0] ir, input logic z, output bit ends);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    cw_t w;
    op = ir[31:26]; fn = ir[5:0]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
    exp_q.delete();
    ends = 0;
    w = blank(); w.s_addr = rs; w.t_addr = rt; exp_q.push_back(w);
    if (op == 6'h00 && fs_map.exists(int'(fn))) begin
      w = blank(); w.s_addr = rs; w.t_addr = rt; w.fs = fs_map[int'(fn)];
      w.y_sel = 3'd2; w.d_addr = rd; w.d_en = 1'b1; exp_q.push_back(w);
    end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
      w = blank(); w.s_addr = rs; w.t_addr = rt;
      w.fs = (fn == 6'h1A) ? 5'h1F : 5'h1E; w.hilo_ld = 1'b1; exp_q.push_back(w);
    end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
      w = blank(); w.y_sel = (fn == 6'h10) ? 3'd4 : 3'd3;
      w.d_addr = rd; w.d_en = 1'b1; exp_q.push_back(w);
    end else if (op == 6'h00 && fn == 6'h08) begin
      w = blank(); w.s_addr = rs; w.t_addr = rt; w.pc_sel = 2'd3; w.pc_ld = 1'b1;
      exp_q.push_back(w);
    end else if (op == 6'h08 || op == 6'h0D) begin
      w = blank(); w.s_addr = rs; w.t_addr = rt; w.t_sel = 1'b1;
      w.ext_sel = (op == 6'h0D); w.fs = (op == 6'h0D) ? 5'h09 : 5'h02;
      w.y_sel = 3'd2; w.d_addr = rt; w.d_en = (rt != 0); exp_q.push_back(w);
    end else if (op == 6'h23) begin
      w = blank(); w.s_addr = rs; w.t_addr = rt; w.fs = 5'h02; w.t_sel = 1'b1; exp_q.push_back(w);
      w = blank(); w.dm_cs = 1'b1; w.dm_rd = 1'b1; exp_q.push_back(w);
      w = blank(); w.y_sel = 3'd1; w.d_addr = rt; w.d_en = (rt != 0); exp_q.push_back(w);
    end else if (op == 6'h2B) begin
      w = blank(); w.s_addr = rs; w.t_addr = rt; w.fs = 5'h02; w.t_sel = 1'b1; exp_q.push_back(w);
      w = blank(); w.s_addr = rs; w.t_addr = rt; w.dm_cs = 1'b1; w.dm_wr = 1'b1; exp_q.push_back(w);
    end else if (op == 6'h04 || op == 6'h05) begin
      w = blank(); w.s_addr = rs; w.t_addr = rt; w.fs = 5'h04; exp_q.push_back(w);
      if ((op == 6'h04) == z) begin
        w = blank(); w.pc_sel = 2'd1; w.pc_ld = 1'b1; exp_q.push_back(w);
      end
    end else if (op == 6'h02) begin
      w = blank(); w.pc_sel = 2'd2; w.pc_ld = 1'b1; exp_q.push_back(w);
    end else if (op == 6'h03) begin
      w = blank(); w.y_sel = 3'd0; w.d_addr = 5'd31; w.d_en = 1'b1; exp_q.push_back(w);
      w = blank(); w.pc_sel = 2'd2; w.pc_ld = 1'b1; exp_q.push_back(w);
    end else begin
      if (op == 6'h00 && fn == 6'h0D) halted = 1;
      else ill = 1;
      exp_q.push_back(blank());
      ends = 1;
    end
  endtask

  // Entered at the negedge of a FETCH cycle; leaves at the next FETCH negedge (or in HALT).
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic z);
    bit ends;
    check({tag, ":fetch"}, fetch_word());
    bus.IR = ir;
    bus.Z = z;
    bus.C = 1'($urandom);
    bus.V = 1'($urandom);
    bus.N = 1'($urandom);
    build_expect(ir, z, ends);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s:step%0d", tag, i), exp_q[i]);
    end
    if (!ends) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    halted = 0;
    ill = 0;
    #1 check("reset_async", reset_word());
    @(negedge clk);
    check("reset_hold", reset_word());
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs = 5'($urandom), rt = 5'($urandom), rd = 5'($urandom), sh = 5'($urandom);
    logic [15:0] imm = 16'($urandom);
    case ($urandom_range(0, 12))
      0:  return {6'h00, rs, rt, rd, sh, 6'(ralu_fn[$urandom_range(0, 12)])};
      1:  return {6'h00, rs, rt, 10'd0, ($urandom_range(0, 1) != 0) ? 6'h1A : 6'h18};
      2:  return {16'd0, rd, 5'd0, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12};
      3:  return {6'h00, rs, 15'd0, 6'h08};
      4:  return {6'h08, rs, rt, imm};
      5:  return {6'h0D, rs, rt, imm};
      6:  return {6'h23, rs, rt, imm};
      7:  return {6'h2B, rs, rt, imm};
      8:  return {6'h04, rs, rt, imm};
      9:  return {6'h05, rs, rt, imm};
      10: return {6'h02, 26'($urandom)};
      11: return {6'h03, 26'($urandom)};
      default: return {6'h00, rs, rt, rd, sh, 6'h20};
    endcase
  endfunction

  initial begin
    fs_map[32'h20] = 5'h02; fs_map[32'h21] = 5'h03; fs_map[32'h22] = 5'h04;
    fs_map[32'h23] = 5'h05; fs_map[32'h2A] = 5'h06; fs_map[32'h2B] = 5'h07;
    fs_map[32'h24] = 5'h08; fs_map[32'h25] = 5'h09; fs_map[32'h26] = 5'h0A;
    fs_map[32'h27] = 5'h0B; fs_map[32'h02] = 5'h0C; fs_map[32'h03] = 5'h0D;
    fs_map[32'h00] = 5'h0E;
    bus.IR = 32'h0; bus.C = 0; bus.V = 0; bus.N = 0; bus.Z = 0;

    // reset held across edges, then released
    @(negedge clk);
    check("reset_state", reset_word());
    @(negedge clk);
    check("reset_state2", reset_word());
    reset = 1'b1;
    @(negedge clk);

    run_instr("add", 32'h014B4820, 1'b0);
    run_instr("lw", 32'h8D280004, 1'b0);
    run_instr("beq_taken", 32'h11090003, 1'b1);
    run_instr("beq_not", 32'h11090003, 1'b0);
    run_instr("bne_taken", 32'h15090003, 1'b0);
    run_instr("div", 32'h0109001A, 1'b0);
    run_instr("mfhi", 32'h00005010, 1'b0);
    run_instr("addi_r0", 32'h21200005, 1'b0);
    run_instr("ori", 32'h3528FFFF, 1'b0);
    run_instr("sw", 32'hAD280008, 1'b0);
    run_instr("jal", 32'h0C000010, 1'b0);
    run_instr("nop_rd0", 32'h00000000, 1'b0);

    for (int i = 0; i < 300; i++)
      run_instr($sformatf("rand%0d", i), rand_instr(), 1'($urandom));

    // reset asserted mid-load: strobes must drop without waiting for a clock
    check("lwrst:fetch", fetch_word());
    bus.IR = 32'h8D280004;
    repeat (3) @(negedge clk);
    begin
      cw_t w = '0;
      w.dm_cs = 1'b1; w.dm_rd = 1'b1;
      check("lwrst:lw2", w);
    end
    #2 reset = 1'b0;
    #1 check("lwrst:abort", reset_word());
    @(negedge clk);
    check("lwrst:held", reset_word());
    reset = 1'b1;
    @(negedge clk);
    run_instr("after_rst", 32'h014B4820, 1'b0);

    // BREAK halts with sticky halt flag
    run_instr("break", 32'h0000000D, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("break_hold", blank());
    end

    do_reset();
    run_instr("illegal", 32'hFC000000, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("illegal_hold", blank());
    end

    do_reset();
    run_instr("post_ill", 32'h0109001A, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
